// File: rtl/tl_pkg.sv
// Shared encodings and helpers for the traffic-light phase controller.
package tl_pkg;

  localparam int unsigned TL_DW   = 7;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned LIGHT_W = 3;

  typedef enum logic [STATE_W-1:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    ALL_RED   = 3'd4
  } tl_state_e;

  // One-hot lamp codes, bit order {red, yellow, green}
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'b001;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'b010;
  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'b100;

  // A zero-length phase would never expire, so it is treated as one cycle
  function automatic int unsigned dur_clamp(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down-counter that saturates at zero, with a registered zero flag.
module tl_phase_timer #(
  parameter int unsigned DW      = 7,
  parameter int unsigned RST_VAL = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] load_val_i,
  output logic [DW-1:0] value_o,
  output logic          zero_o
);

  logic [DW-1:0] value_q, value_d;
  logic          zero_q, zero_d;

  // Load takes priority; otherwise count down and hold at zero
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (value_q != '0) begin
      value_d = value_q - DW'(1);
    end
    zero_d = (value_d == '0);
  end

  // Counter and zero flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= DW'(RST_VAL);
      zero_q  <= (DW'(RST_VAL) == '0);
    end else begin
      value_q <= value_d;
      zero_q  <= zero_d;
    end
  end

  assign value_o = value_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/tl_phase_ctrl.sv
// Intersection phase sequencer: light phases, pedestrian walk, emergency
// all-red override and boundary-applied duration reconfiguration.
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned DW       = TL_DW,
  parameter int unsigned GREEN_NS = 40,
  parameter int unsigned GREEN_EW = 20,
  parameter int unsigned YELLOW   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ped_req_ns,
  input  logic               ped_req_ew,
  input  logic               emerg,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DW-1:0]      cfg_green_ns,
  input  logic [DW-1:0]      cfg_green_ew,
  input  logic [DW-1:0]      cfg_yellow,
  output logic [STATE_W-1:0] state,
  output logic [DW-1:0]      remain,
  output logic [LIGHT_W-1:0] ns_light,
  output logic [LIGHT_W-1:0] ew_light,
  output logic               walk_ns,
  output logic               walk_ew,
  output logic               cycle_done
);

  localparam int unsigned RST_REMAIN = dur_clamp(GREEN_NS) - 32'd1;

  tl_state_e            state_q, state_d;
  logic                 boundary;
  logic                 entering;
  logic                 xfer;

  logic [DW-1:0]        act_gns_q, act_gns_d, act_gew_q, act_gew_d, act_yel_q, act_yel_d;
  logic [DW-1:0]        shd_gns_q, shd_gns_d, shd_gew_q, shd_gew_d, shd_yel_q, shd_yel_d;
  logic                 shd_valid_q, shd_valid_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
  logic                 walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
  logic                 cycle_done_q, cycle_done_d;
  logic [LIGHT_W-1:0]   ns_light_q, ns_light_d, ew_light_q, ew_light_d;

  logic                 tmr_load;
  logic [DW-1:0]        tmr_val;
  logic [DW-1:0]        tmr_value;
  logic                 tmr_zero;

  // Timer reload value for a duration: clamp then subtract one
  function automatic logic [DW-1:0] load_of(input logic [DW-1:0] d);
    return DW'(dur_clamp(32'(d)) - 32'd1);
  endfunction

  tl_phase_timer #(
    .DW      (DW),
    .RST_VAL (RST_REMAIN)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .value_o    (tmr_value),
    .zero_o     (tmr_zero)
  );

  // Phase state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= NS_GREEN;
    else        state_q <= state_d;
  end

  // Phase sequencing, emergency override and boundary detection
  always_comb begin
    state_d  = state_q;
    boundary = 1'b0;
    case (state_q)
      NS_GREEN:  if (emerg || tmr_zero) state_d = NS_YELLOW;
      NS_YELLOW: if (tmr_zero) state_d = emerg ? ALL_RED : EW_GREEN;
      EW_GREEN:  if (emerg || tmr_zero) state_d = EW_YELLOW;
      EW_YELLOW: begin
        if (tmr_zero) begin
          state_d  = emerg ? ALL_RED : NS_GREEN;
          boundary = !emerg;
        end
      end
      ALL_RED: begin
        if (!emerg) begin
          state_d  = NS_GREEN;
          boundary = 1'b1;
        end
      end
      default: state_d = NS_GREEN;
    endcase
  end

  // Config shadow/active, timer reload, pedestrian service and lamp decode
  always_comb begin
    xfer        = cfg_valid && cfg_ready_q;
    entering    = (state_d != state_q);

    act_gns_d   = act_gns_q;
    act_gew_d   = act_gew_q;
    act_yel_d   = act_yel_q;
    shd_gns_d   = shd_gns_q;
    shd_gew_d   = shd_gew_q;
    shd_yel_d   = shd_yel_q;
    shd_valid_d = shd_valid_q;
    cfg_ready_d = !shd_valid_q;

    if (boundary && shd_valid_q) begin
      act_gns_d   = shd_gns_q;
      act_gew_d   = shd_gew_q;
      act_yel_d   = shd_yel_q;
      shd_valid_d = 1'b0;
    end
    if (xfer) begin
      shd_gns_d   = cfg_green_ns;
      shd_gew_d   = cfg_green_ew;
      shd_yel_d   = cfg_yellow;
      shd_valid_d = 1'b1;
      cfg_ready_d = 1'b0;
    end

    tmr_load = entering || (state_q == ALL_RED);
    tmr_val  = '0;
    case (state_d)
      NS_GREEN:             tmr_val = load_of(act_gns_d);
      EW_GREEN:             tmr_val = load_of(act_gew_d);
      NS_YELLOW, EW_YELLOW: tmr_val = load_of(act_yel_d);
      default:              tmr_val = '0;
    endcase

    pend_ns_d = pend_ns_q || ped_req_ns;
    walk_ns_d = 1'b0;
    if (state_d == NS_GREEN) begin
      if (entering) begin
        walk_ns_d = pend_ns_q || ped_req_ns;
        pend_ns_d = 1'b0;
      end else begin
        walk_ns_d = walk_ns_q;
      end
    end

    pend_ew_d = pend_ew_q || ped_req_ew;
    walk_ew_d = 1'b0;
    if (state_d == EW_GREEN) begin
      if (entering) begin
        walk_ew_d = pend_ew_q || ped_req_ew;
        pend_ew_d = 1'b0;
      end else begin
        walk_ew_d = walk_ew_q;
      end
    end

    cycle_done_d = boundary;

    ns_light_d = LIGHT_RED;
    ew_light_d = LIGHT_RED;
    case (state_d)
      NS_GREEN:  ns_light_d = LIGHT_GREEN;
      NS_YELLOW: ns_light_d = LIGHT_YELLOW;
      EW_GREEN:  ew_light_d = LIGHT_GREEN;
      EW_YELLOW: ew_light_d = LIGHT_YELLOW;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_gns_q    <= DW'(GREEN_NS);
      act_gew_q    <= DW'(GREEN_EW);
      act_yel_q    <= DW'(YELLOW);
      shd_gns_q    <= '0;
      shd_gew_q    <= '0;
      shd_yel_q    <= '0;
      shd_valid_q  <= 1'b0;
      cfg_ready_q  <= 1'b1;
      pend_ns_q    <= 1'b0;
      pend_ew_q    <= 1'b0;
      walk_ns_q    <= 1'b0;
      walk_ew_q    <= 1'b0;
      cycle_done_q <= 1'b0;
      ns_light_q   <= LIGHT_GREEN;
      ew_light_q   <= LIGHT_RED;
    end else begin
      act_gns_q    <= act_gns_d;
      act_gew_q    <= act_gew_d;
      act_yel_q    <= act_yel_d;
      shd_gns_q    <= shd_gns_d;
      shd_gew_q    <= shd_gew_d;
      shd_yel_q    <= shd_yel_d;
      shd_valid_q  <= shd_valid_d;
      cfg_ready_q  <= cfg_ready_d;
      pend_ns_q    <= pend_ns_d;
      pend_ew_q    <= pend_ew_d;
      walk_ns_q    <= walk_ns_d;
      walk_ew_q    <= walk_ew_d;
      cycle_done_q <= cycle_done_d;
      ns_light_q   <= ns_light_d;
      ew_light_q   <= ew_light_d;
    end
  end

  assign state      = state_q;
  assign remain     = tmr_value;
  assign ns_light   = ns_light_q;
  assign ew_light   = ew_light_q;
  assign walk_ns    = walk_ns_q;
  assign walk_ew    = walk_ew_q;
  assign cycle_done = cycle_done_q;
  assign cfg_ready  = cfg_ready_q;

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// Self-checking bench for tl_phase_ctrl against a phase-elapsed reference model.
module tb_tl_phase_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ped_req_ns, ped_req_ew, emerg, cfg_valid;
  logic       cfg_ready;
  logic [6:0] cfg_green_ns, cfg_green_ew, cfg_yellow;
  logic [2:0] state;
  logic [6:0] remain;
  logic [2:0] ns_light, ew_light;
  logic       walk_ns, walk_ew, cycle_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: phase index, cycles elapsed in phase, phase length
  int m_phase, m_el, m_dur;
  int act[3];          // 0: green NS, 1: green EW, 2: yellow
  int shd[3];
  bit shd_full, m_ready, m_done;
  bit m_pend[2], m_walk[2];

  tl_phase_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ped_req_ns   (ped_req_ns),
    .ped_req_ew   (ped_req_ew),
    .emerg        (emerg),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_green_ns (cfg_green_ns),
    .cfg_green_ew (cfg_green_ew),
    .cfg_yellow   (cfg_yellow),
    .state        (state),
    .remain       (remain),
    .ns_light     (ns_light),
    .ew_light     (ew_light),
    .walk_ns      (walk_ns),
    .walk_ew      (walk_ew),
    .cycle_done   (cycle_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [19:0] RESET_VEC = {3'd0, 7'd39, 3'b001, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1};

  function automatic int clampd(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int phase_len(input int p);
    case (p)
      0:       return clampd(act[0]);
      2:       return clampd(act[1]);
      1, 3:    return clampd(act[2]);
      default: return 1;
    endcase
  endfunction

  function automatic logic [19:0] obs();
    return {state, remain, ns_light, ew_light, walk_ns, walk_ew, cycle_done, cfg_ready};
  endfunction

  function automatic logic [19:0] exp_vec();
    logic [2:0] ns, ew;
    ns = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
    ew = (m_phase == 2) ? 3'b001 : (m_phase == 3) ? 3'b010 : 3'b100;
    return {3'(m_phase), 7'(m_dur - 1 - m_el), ns, ew, m_walk[0], m_walk[1], m_done, m_ready};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_el = 0;
    act[0] = 40; act[1] = 20; act[2] = 5;
    shd_full = 0; m_ready = 1; m_done = 0;
    m_pend[0] = 0; m_pend[1] = 0; m_walk[0] = 0; m_walk[1] = 0;
    m_dur = phase_len(0);
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled
  task automatic model_step();
    bit last, bnd, xfer, req;
    int nxt;
    bit pr[2];
    pr[0] = ped_req_ns; pr[1] = ped_req_ew;
    xfer = cfg_valid && m_ready;
    last = (m_el == m_dur - 1);
    nxt  = m_phase;
    bnd  = 0;
    case (m_phase)
      0: if (emerg || last) nxt = 1;
      1: if (last) nxt = emerg ? 4 : 2;
      2: if (emerg || last) nxt = 3;
      3: if (last) begin nxt = emerg ? 4 : 0; bnd = !emerg; end
      default: if (!emerg) begin nxt = 0; bnd = 1; end
    endcase
    // ready returns only one cycle after the shadow has drained
    m_ready = xfer ? 1'b0 : !shd_full;
    if (bnd && shd_full) begin act = shd; shd_full = 0; end
    if (xfer) begin
      shd[0] = int'(cfg_green_ns); shd[1] = int'(cfg_green_ew); shd[2] = int'(cfg_yellow);
      shd_full = 1;
    end
    for (int d = 0; d < 2; d++) begin
      req = m_pend[d] || pr[d];
      if (nxt == 2 * d && m_phase != 2 * d) begin
        m_walk[d] = req; m_pend[d] = 0;
      end else if (nxt == 2 * d) begin
        m_pend[d] = req;
      end else begin
        m_walk[d] = 0; m_pend[d] = req;
      end
    end
    m_done = bnd;
    if (nxt != m_phase) begin
      m_el = 0; m_dur = phase_len(nxt);
    end else if (m_phase != 4) begin
      m_el++;
    end
    m_phase = nxt;
  endtask

  task automatic clear_inputs();
    ped_req_ns = 0; ped_req_ew = 0; emerg = 0; cfg_valid = 0;
    cfg_green_ns = '0; cfg_green_ew = '0; cfg_yellow = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== RESET_VEC) begin
      errors++; $display("FAIL reset_vec got=%h exp=%h", obs(), RESET_VEC);
    end
  endtask

  task automatic test_default_cycle();
    int ndone, first_done;
    ndone = 0; first_done = -1;
    do_reset();
    repeat (141) begin
      tick();
      if (cycle_done === 1'b1) begin ndone++; if (first_done < 0) first_done = cyc; end
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL default cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
    end
    checks++;
    if (first_done != 70 || ndone != 2) begin
      errors++; $display("FAIL default_done first=%0d count=%0d exp first=70 count=2", first_done, ndone);
    end
  endtask

  task automatic test_ped();
    int w1, w2;
    w1 = 0; w2 = 0;
    do_reset();
    repeat (140) begin
      ped_req_ew = (cyc == 10 || cyc == 50);
      tick();
      if (walk_ew === 1'b1) begin if (cyc < 70) w1++; else w2++; end
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL ped cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
    end
    clear_inputs();
    checks++;
    if (w1 != 20 || w2 != 20) begin
      errors++; $display("FAIL ped_walk_len got=%0d/%0d exp=20/20", w1, w2);
    end
  endtask

  task automatic test_emerg();
    do_reset();
    repeat (100) begin
      emerg = (cyc >= 50 && cyc < 80);
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL emerg cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
      if (cyc == 60) begin
        checks++;
        if (state !== 3'd4 || ns_light !== 3'b100 || ew_light !== 3'b100) begin
          errors++; $display("FAIL emerg_allred got=%0d exp=4", state);
        end
      end
      if (cyc == 81) begin
        checks++;
        if (state !== 3'd0 || remain !== 7'd39) begin
          errors++; $display("FAIL emerg_exit got=%0d/%0d exp=0/39", state, remain);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_cfg();
    do_reset();
    repeat (150) begin
      cfg_valid = (cyc == 20);
      cfg_green_ns = 7'd30; cfg_green_ew = 7'd10; cfg_yellow = 7'd3;
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL cfg cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
      if (cyc == 21 || cyc == 70 || cyc == 71) begin
        checks++;
        if (cfg_ready !== (cyc == 71)) begin
          errors++; $display("FAIL cfg_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, cyc == 71);
        end
      end
      if (cyc == 70) begin
        checks++;
        if (remain !== 7'd29) begin
          errors++; $display("FAIL cfg_new_load got=%0d exp=29", remain);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_zero_cfg();
    do_reset();
    repeat (90) begin
      cfg_valid = (cyc == 0);
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL zero cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
      if (cyc >= 70) begin
        checks++;
        if (state !== 3'((cyc - 70) % 4)) begin
          errors++; $display("FAIL zero_seq cyc=%0d got=%0d exp=%0d", cyc, state, (cyc - 70) % 4);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    while (cyc < 47) begin
      ped_req_ns = (cyc == 5);
      cfg_valid  = (cyc == 10);
      cfg_green_ns = 7'd9; cfg_green_ew = 7'd9; cfg_yellow = 7'd2;
      tick();
    end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== RESET_VEC) begin
      errors++; $display("FAIL mid_reset got=%h exp=%h", obs(), RESET_VEC);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    repeat (80) begin
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (3000) begin
      ped_req_ns = ($urandom_range(0, 15) == 0);
      ped_req_ew = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) emerg = !emerg;
      cfg_valid    = ($urandom_range(0, 9) == 0);
      cfg_green_ns = 7'($urandom_range(0, 12));
      cfg_green_ew = 7'($urandom_range(0, 12));
      cfg_yellow   = 7'($urandom_range(0, 4));
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), exp_vec());
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_default_cycle();
    test_ped();
    test_emerg();
    test_cfg();
    test_zero_cfg();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
